// File: rtl/tty_pkg.sv
// Shared constants, source indices and FSM state types for the TTY character arbiter.
package tty_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SRC_CPU = 0;
  localparam int unsigned SRC_KB  = 1;
  localparam int unsigned SRC_RX  = 2;

  typedef enum logic [1:0] {V_IDLE, V_ISSUE, V_HOLD} vga_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;

  // Next source index in round-robin order (wraps after the last source).
  function automatic logic [1:0] src_next(input logic [1:0] src);
    return (src == 2'(NUM_SRC - 1)) ? 2'd0 : src + 2'd1;
  endfunction

endpackage

// File: rtl/tty_key_fifo.sv
// Synchronous keystroke FIFO with first-word-fall-through head, empty/full flags and a
// drop indication for pushes that arrive while full.
module tty_key_fifo
  import tty_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [CHAR_W-1:0] EMPTY_CHAR = 8'hFF
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_data,
  input  logic              pop,
  output logic [CHAR_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [CHAR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;
  assign head    = empty ? EMPTY_CHAR : mem_q[rd_ptr_q];

  always_ff @(posedge clk_50mhz) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tty_char_arbiter.sv
// Shares the VGA text writer among CPU, keyboard and UART RX sources and buffers keystrokes.
// Define TTY_LOCAL_ECHO_EN to echo keyboard characters to the UART transmitter.
module tty_char_arbiter
  import tty_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter int unsigned       VM_GAP     = 2,
  parameter logic [CHAR_W-1:0] EMPTY_CHAR = 8'hFF
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               cpu_wr,
  input  logic [CHAR_W-1:0]  cpu_wdata,
  input  logic               cpu_rd,
  output logic [CHAR_W-1:0]  cpu_rdata,
  input  logic               kb_valid,
  input  logic [CHAR_W-1:0]  kb_ascii,
  input  logic               rx_ready,
  input  logic [CHAR_W-1:0]  rx_data,
  output logic               vm_write,
  output logic [CHAR_W-1:0]  vm_data,
  input  logic               vm_busy,
  output logic               tx_start,
  output logic [CHAR_W-1:0]  tx_data,
  input  logic               tx_busy,
  output logic [NUM_SRC-1:0] overrun,
  output logic               fifo_empty,
  output logic               fifo_full
);

  localparam int unsigned GapW = $clog2(VM_GAP + 2);

  logic [NUM_SRC-1:0]             src_stb;
  logic [NUM_SRC-1:0][CHAR_W-1:0] src_data;
  logic [NUM_SRC-1:0]             slot_v_q;
  logic [NUM_SRC-1:0][CHAR_W-1:0] slot_d_q;
  logic [NUM_SRC-1:0]             slot_grant;
  logic [NUM_SRC-1:0]             slot_drop;
  logic [NUM_SRC-1:0]             kb_extra_drop;
  logic [NUM_SRC-1:0]             overrun_q;
  logic [1:0]                     rr_ptr_q;
  logic [1:0]                     grant_idx;
  logic [1:0]                     cand;
  logic                           grant_vld;
  vga_state_t                     vga_state_q;
  vga_state_t                     vga_state_d;
  logic [GapW-1:0]                gap_q;
  logic                           gap_done;
  logic [CHAR_W-1:0]              vm_data_q;
  logic                           fifo_drop;
  logic                           echo_drop;

  always_comb begin
    src_stb           = '0;
    src_data          = '0;
    src_stb[SRC_CPU]  = cpu_wr;
    src_stb[SRC_KB]   = kb_valid;
    src_stb[SRC_RX]   = rx_ready;
    src_data[SRC_CPU] = cpu_wdata;
    src_data[SRC_KB]  = kb_ascii;
    src_data[SRC_RX]  = rx_data;
  end

  // Round-robin search over pending slots, starting at rr_ptr_q; only grants while idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!grant_vld && slot_v_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = src_next(cand);
    end
    if (vga_state_q != V_IDLE) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    slot_grant    = '0;
    slot_drop     = '0;
    kb_extra_drop = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      slot_grant[i] = grant_vld && (grant_idx == 2'(i));
      slot_drop[i]  = src_stb[i] && slot_v_q[i] && !slot_grant[i];
    end
    kb_extra_drop[SRC_KB] = fifo_drop || echo_drop;
  end

  // A strobe on the grant cycle refills the slot, so it simply stays valid.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      slot_v_q  <= '0;
      slot_d_q  <= '0;
      overrun_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (src_stb[i] && !slot_drop[i]) begin
          slot_v_q[i] <= 1'b1;
          slot_d_q[i] <= src_data[i];
        end else if (slot_grant[i]) begin
          slot_v_q[i] <= 1'b0;
        end
      end
      overrun_q <= overrun_q | slot_drop | kb_extra_drop;
    end
  end

  // VGA FSM.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      vga_state_q <= V_IDLE;
    end else begin
      vga_state_q <= vga_state_d;
    end
  end

  assign gap_done = (32'(gap_q) + 32'd1) >= VM_GAP;

  always_comb begin
    vga_state_d = vga_state_q;
    unique case (vga_state_q)
      V_IDLE:  if (grant_vld) vga_state_d = V_ISSUE;
      V_ISSUE: vga_state_d = V_HOLD;
      V_HOLD:  if (gap_done && !vm_busy) vga_state_d = V_IDLE;
      default: vga_state_d = V_IDLE;
    endcase
  end

  always_comb begin
    vm_write = (vga_state_q == V_ISSUE);
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      gap_q     <= '0;
      vm_data_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (grant_vld) begin
        vm_data_q <= slot_d_q[grant_idx];
        rr_ptr_q  <= src_next(grant_idx);
      end
      if (vga_state_q != V_HOLD) begin
        gap_q <= '0;
      end else if (!gap_done) begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end

  assign vm_data = vm_data_q;
  assign overrun = overrun_q;

  tty_key_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .EMPTY_CHAR(EMPTY_CHAR)
  ) u_key_fifo (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .push     (kb_valid),
    .push_data(kb_ascii),
    .pop      (cpu_rd),
    .head     (cpu_rdata),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

`ifdef TTY_LOCAL_ECHO_EN
  logic              echo_v_q;
  logic [CHAR_W-1:0] echo_d_q;
  logic              echo_grant;
  logic [CHAR_W-1:0] tx_data_q;
  tx_state_t         tx_state_q;
  tx_state_t         tx_state_d;

  assign echo_grant = (tx_state_q == T_IDLE) && echo_v_q;
  assign echo_drop  = kb_valid && echo_v_q && !echo_grant;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      echo_v_q  <= 1'b0;
      echo_d_q  <= '0;
      tx_data_q <= '0;
    end else begin
      if (kb_valid && !echo_drop) begin
        echo_v_q <= 1'b1;
        echo_d_q <= kb_ascii;
      end else if (echo_grant) begin
        echo_v_q <= 1'b0;
      end
      if (echo_grant) begin
        tx_data_q <= echo_d_q;
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      tx_state_q <= T_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      T_IDLE:  if (echo_v_q) tx_state_d = T_START;
      T_START: tx_state_d = T_WAIT;
      T_WAIT:  if (!tx_busy) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (tx_state_q == T_START);
  end

  assign tx_data = tx_data_q;
`else
  logic unused_tx_busy;

  assign unused_tx_busy = tx_busy;
  assign echo_drop      = 1'b0;
  assign tx_start       = 1'b0;
  assign tx_data        = '0;
`endif

endmodule
